// File: rtl/parser_lane_sched_pkg.sv
// Shared types, defaults and helpers for the parser lane scheduler.
package parser_sched_pkg;

   localparam int unsigned PKT_HDR_LEN      = 800;
   localparam int unsigned C_PHV_WIDTH_DEF  = PKT_HDR_LEN * 8;
   localparam int unsigned C_NUM_LANES_DEF  = 2;
   localparam int unsigned C_LANE_DEPTH_DEF = 2;

   typedef logic [$clog2(C_NUM_LANES_DEF)-1:0] lane_idx_t;
   typedef logic [$clog2(C_LANE_DEPTH_DEF):0]  credit_t;

   // Wrapping pointer increment over n slots.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/parser_lane_sched_if.sv
// Segment-input and ordered-PHV-output handshake bundle of the lane scheduler.
interface parser_lane_sched_if
   import parser_sched_pkg::*;
#(
   parameter int unsigned C_PHV_WIDTH = C_PHV_WIDTH_DEF
);
   logic                   in_valid;
   logic                   in_ready;
   logic [C_PHV_WIDTH-1:0] out_phv;
   logic                   out_valid;
   logic                   out_ready;

   modport master (output in_valid, input in_ready,
                   input out_phv, input out_valid, output out_ready);
   modport slave  (input in_valid, output in_ready,
                   output out_phv, output out_valid, input out_ready);
endinterface

// File: rtl/parser_lane_sched_buf.sv
// Per-lane result buffer: small register FIFO with full/empty and head view.
module parser_lane_buf
   import parser_sched_pkg::*;
#(
   parameter int unsigned C_DEPTH = C_LANE_DEPTH_DEF,
   parameter int unsigned C_WIDTH = C_PHV_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [C_WIDTH-1:0] din,
   output logic               full,
   output logic               empty,
   output logic [C_WIDTH-1:0] head
);
   localparam int unsigned AW   = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
   localparam int unsigned CNTW = $clog2(C_DEPTH) + 1;

   logic [C_WIDTH-1:0] mem [C_DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [CNTW-1:0]    count;

   assign full  = (count == CNTW'(C_DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == AW'(C_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (pop)  rd_ptr <= (rd_ptr == AW'(C_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/parser_lane_sched.sv
// Order-preserving round-robin scheduler over C_NUM_LANES parser lanes.
// Optional PARSER_LANE_SCHED_STATS_EN adds saturating dispatch/emit/stall counters.
module parser_lane_sched
   import parser_sched_pkg::*;
#(
   parameter int unsigned C_NUM_LANES  = C_NUM_LANES_DEF,
   parameter int unsigned C_LANE_IDX_W = $clog2(C_NUM_LANES),
   parameter int unsigned C_PHV_WIDTH  = C_PHV_WIDTH_DEF,
   parameter int unsigned C_LANE_DEPTH = C_LANE_DEPTH_DEF
) (
   input  logic                               clk,
   input  logic                               reset,
   parser_lane_sched_if.slave                 bus,
   output logic [C_NUM_LANES-1:0]             lane_start,
   input  logic [C_NUM_LANES-1:0]             lane_done,
   input  logic [C_NUM_LANES*C_PHV_WIDTH-1:0] lane_phv,
   output logic                               err_overflow
`ifdef PARSER_LANE_SCHED_STATS_EN
   ,
   output logic [31:0]                        stat_dispatched,
   output logic [31:0]                        stat_emitted,
   output logic [31:0]                        stat_credit_stall
`endif
);
   localparam int unsigned CW = $clog2(C_LANE_DEPTH) + 1;

   typedef logic [C_LANE_IDX_W-1:0] ptr_t;
   typedef logic [CW-1:0]           cnt_t;

   ptr_t                   disp_q, out_q;
   cnt_t                   credit [C_NUM_LANES];
   logic                   fire, load;
   logic [C_NUM_LANES-1:0] buf_full, buf_empty, buf_pop;
   logic [C_PHV_WIDTH-1:0] buf_head [C_NUM_LANES];

   assign bus.in_ready = (credit[disp_q] != '0) & ~reset;
   assign fire         = bus.in_valid & bus.in_ready;
   assign load         = (~bus.out_valid | bus.out_ready) & ~buf_empty[out_q];

   always_comb begin
      lane_start = '0;
      buf_pop    = '0;
      if (fire) lane_start[disp_q] = 1'b1;
      if (load) buf_pop[out_q]     = 1'b1;
   end

   for (genvar i = 0; i < C_NUM_LANES; i++) begin : g_lane
      parser_lane_buf #(
         .C_DEPTH (C_LANE_DEPTH),
         .C_WIDTH (C_PHV_WIDTH)
      ) u_buf (
         .clk   (clk),
         .reset (reset),
         .push  (lane_done[i] & ~buf_full[i]),
         .pop   (buf_pop[i]),
         .din   (lane_phv[i*C_PHV_WIDTH +: C_PHV_WIDTH]),
         .full  (buf_full[i]),
         .empty (buf_empty[i]),
         .head  (buf_head[i])
      );

      a_credit_max: assert property (@(posedge clk) disable iff (reset)
         credit[i] <= CW'(C_LANE_DEPTH));
      a_credit_overshoot: assert property (@(posedge clk) disable iff (reset)
         !(buf_pop[i] && !lane_start[i] && credit[i] == CW'(C_LANE_DEPTH)));
   end

   // Dispatch and pop on the same lane cancel out, leaving the credit unchanged.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < C_NUM_LANES; i++) begin
         if (reset) begin
            credit[i] <= CW'(C_LANE_DEPTH);
         end else begin
            case ({lane_start[i], buf_pop[i]})
               2'b10:   credit[i] <= credit[i] - CW'(1);
               2'b01:   credit[i] <= credit[i] + CW'(1);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         disp_q        <= '0;
         out_q         <= '0;
         bus.out_phv   <= '0;
         bus.out_valid <= 1'b0;
         err_overflow  <= 1'b0;
      end else begin
         if (fire) disp_q <= ptr_t'(ptr_inc(32'(disp_q), C_NUM_LANES));
         if (load) begin
            bus.out_phv   <= buf_head[out_q];
            bus.out_valid <= 1'b1;
            out_q         <= ptr_t'(ptr_inc(32'(out_q), C_NUM_LANES));
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         if (|(lane_done & buf_full)) err_overflow <= 1'b1;
      end
   end

`ifdef PARSER_LANE_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_dispatched   <= '0;
         stat_emitted      <= '0;
         stat_credit_stall <= '0;
      end else begin
         if (fire && stat_dispatched != '1)
            stat_dispatched <= stat_dispatched + 32'd1;
         if (bus.out_valid && bus.out_ready && stat_emitted != '1)
            stat_emitted <= stat_emitted + 32'd1;
         if (bus.in_valid && !bus.in_ready && stat_credit_stall != '1)
            stat_credit_stall <= stat_credit_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_parser_lane_sched.sv
// Directed bench for parser_lane_sched: ordering, credit stall, hold, overflow, reset.
module tb_parser_lane_sched;
   localparam int unsigned W = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   parser_lane_sched_if #(.C_PHV_WIDTH(W)) bus ();
   parser_lane_sched_if #(.C_PHV_WIDTH(W)) bus1 ();

   logic [1:0]     lane_start, lane_done, lane_start1, lane_done1;
   logic [2*W-1:0] lane_phv, lane_phv1;
   logic           err_overflow, err_overflow1;
`ifdef PARSER_LANE_SCHED_STATS_EN
   logic [31:0]    st_disp, st_emit, st_stall, st_disp1, st_emit1, st_stall1;
`endif

   parser_lane_sched #(
      .C_NUM_LANES (2), .C_LANE_IDX_W (1), .C_PHV_WIDTH (W), .C_LANE_DEPTH (2)
   ) dut (
      .clk (clk), .reset (reset), .bus (bus),
      .lane_start (lane_start), .lane_done (lane_done), .lane_phv (lane_phv),
      .err_overflow (err_overflow)
`ifdef PARSER_LANE_SCHED_STATS_EN
      , .stat_dispatched (st_disp), .stat_emitted (st_emit), .stat_credit_stall (st_stall)
`endif
   );

   parser_lane_sched #(
      .C_NUM_LANES (2), .C_LANE_IDX_W (1), .C_PHV_WIDTH (W), .C_LANE_DEPTH (1)
   ) dut1 (
      .clk (clk), .reset (reset), .bus (bus1),
      .lane_start (lane_start1), .lane_done (lane_done1), .lane_phv (lane_phv1),
      .err_overflow (err_overflow1)
`ifdef PARSER_LANE_SCHED_STATS_EN
      , .stat_dispatched (st_disp1), .stat_emitted (st_emit1), .stat_credit_stall (st_stall1)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic dispatch(input string tag, input logic [1:0] exp_start);
      bus.in_valid = 1'b1;
      #1;
      check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      check(tag, 32'(lane_start), 32'(exp_start));
      tick();
   endtask

   task automatic done(input logic [1:0] d, input logic [W-1:0] p1, input logic [W-1:0] p0);
      lane_done = d;
      lane_phv  = {p1, p0};
      tick();
      lane_done = '0;
   endtask

   task automatic out_chk(input string tag, input logic v, input logic [W-1:0] p);
      check({tag, "_v"}, 32'(bus.out_valid), 32'(v));
      check({tag, "_phv"}, 32'(bus.out_phv), 32'(p));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
      lane_done = '0;  lane_phv = '0;
      lane_done1 = '0; lane_phv1 = '0;
      tick();
      // Reset state, with in_valid high to show reset gates in_ready
      bus.in_valid = 1'b1;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_lane_start", 32'(lane_start), 32'd0);
      out_chk("rst_out", 1'b0, 16'h0000);
      check("rst_err", 32'(err_overflow), 32'd0);
      tick();
      bus.in_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      tick();

      // Ordering: lane 1 finishes early, lane 0 late
      bus.out_ready = 1'b1;
      dispatch("disp_a", 2'b01); dispatch("disp_b", 2'b10);
      dispatch("disp_c", 2'b01); dispatch("disp_d", 2'b10);
      bus.in_valid = 1'b0;
      #1;
      check("ord_no_credit", 32'(bus.in_ready), 32'd0);
      done(2'b10, 16'hB1B1, 16'h0);  check("ord_wait1", 32'(bus.out_valid), 32'd0);
      done(2'b10, 16'hD3D3, 16'h0);  check("ord_wait2", 32'(bus.out_valid), 32'd0);
      tick();                        check("ord_wait3", 32'(bus.out_valid), 32'd0);
      done(2'b01, 16'h0, 16'hA0A0);  check("ord_wait4", 32'(bus.out_valid), 32'd0);
      done(2'b01, 16'h0, 16'hC2C2);  out_chk("ord_a", 1'b1, 16'hA0A0);
      tick();                        out_chk("ord_b", 1'b1, 16'hB1B1);
      tick();                        out_chk("ord_c", 1'b1, 16'hC2C2);
      tick();                        out_chk("ord_d", 1'b1, 16'hD3D3);
      tick();                        out_chk("ord_drain", 1'b0, 16'hD3D3);
      check("ord_credit_back", 32'(bus.in_ready), 32'd1);

      // Credit stall with the output blocked
      bus.out_ready = 1'b0;
      dispatch("disp_e", 2'b01); dispatch("disp_f", 2'b10);
      dispatch("disp_g", 2'b01); dispatch("disp_h", 2'b10);
      #1;
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_lane_start", 32'(lane_start), 32'd0);
`ifdef PARSER_LANE_SCHED_STATS_EN
      check("stat_stall_pre", st_stall, 32'd0);
`endif
      tick();
      bus.in_valid = 1'b0;
`ifdef PARSER_LANE_SCHED_STATS_EN
      check("stat_stall_post", st_stall, 32'd1);
`endif
      done(2'b11, 16'hF5F5, 16'hE4E4);  check("stall_wait", 32'(bus.out_valid), 32'd0);
      done(2'b11, 16'h1717, 16'h6666);  out_chk("hold_e0", 1'b1, 16'hE4E4);
      check("stall_release", 32'(bus.in_ready), 32'd1);

      // Hold: out_ready toggling
      tick();                              out_chk("hold_e1", 1'b1, 16'hE4E4);
      bus.out_ready = 1'b1; tick();        out_chk("hold_f0", 1'b1, 16'hF5F5);
      bus.out_ready = 1'b0; tick();        out_chk("hold_f1", 1'b1, 16'hF5F5);
      bus.out_ready = 1'b1; tick();        out_chk("hold_g0", 1'b1, 16'h6666);
      bus.out_ready = 1'b0; tick();        out_chk("hold_g1", 1'b1, 16'h6666);
      bus.out_ready = 1'b1; tick();        out_chk("hold_h0", 1'b1, 16'h1717);
      tick();                              out_chk("hold_drain", 1'b0, 16'h1717);
`ifdef PARSER_LANE_SCHED_STATS_EN
      check("stat_disp", st_disp, 32'd8);
      check("stat_emit", st_emit, 32'd8);
      check("stat_stall_final", st_stall, 32'd1);
`endif

      // Simultaneous dispatch and pop on lane 0 with one credit left
      dispatch("disp_i", 2'b01); dispatch("disp_j", 2'b10);
      bus.in_valid = 1'b0;
      done(2'b01, 16'h0, 16'h8888);
      dispatch("disp_k_simul", 2'b01);     out_chk("simul_i", 1'b1, 16'h8888);
      dispatch("disp_l", 2'b10);
      bus.in_valid = 1'b0;
      #1;
      check("simul_credit_kept", 32'(bus.in_ready), 32'd1);
      check("simul_out_idle", 32'(bus.out_valid), 32'd0);
      dispatch("disp_m", 2'b01);
      bus.in_valid = 1'b0;
      #1;
      check("simul_lane1_empty", 32'(bus.in_ready), 32'd0);

      // Overflow on the depth-1 instance
      bus1.in_valid = 1'b1;
      #1;
      check("ovf_start", 32'(lane_start1), 32'd1);
      tick();
      bus1.in_valid = 1'b0;
      lane_done1 = 2'b01; lane_phv1 = {16'h0, 16'h5A5A}; tick();
      check("ovf_first_ok", 32'(err_overflow1), 32'd0);
      lane_done1 = 2'b01; lane_phv1 = {16'h0, 16'hDEAD}; tick();
      lane_done1 = '0;
      check("ovf_err", 32'(err_overflow1), 32'd1);
      check("ovf_v", 32'(bus1.out_valid), 32'd1);
      check("ovf_phv", 32'(bus1.out_phv), 32'h5A5A);
      bus1.out_ready = 1'b1; tick();
      check("ovf_no_dup", 32'(bus1.out_valid), 32'd0);
      check("ovf_sticky", 32'(err_overflow1), 32'd1);

      // Mid-flight reset with K, M and L buffered behind J
      bus.out_ready = 1'b0;
      done(2'b11, 16'h9999, 16'hAAAA);  check("mid_wait", 32'(bus.out_valid), 32'd0);
      done(2'b11, 16'hBBBB, 16'hCCCC);  out_chk("mid_j", 1'b1, 16'h9999);
      reset = 1'b1; bus.in_valid = 1'b1;
      lane_done = 2'b01; lane_phv = {16'h0, 16'hEEEE};
      #1;
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("mid_rst_lane_start", 32'(lane_start), 32'd0);
      tick();
      reset = 1'b0; bus.in_valid = 1'b0; lane_done = '0;
      #1;
      out_chk("mid_after", 1'b0, 16'h0000);
      check("mid_in_ready", 32'(bus.in_ready), 32'd1);
      check("mid_err_clear", 32'(err_overflow), 32'd0);
      check("mid_err1_clear", 32'(err_overflow1), 32'd0);
      bus.out_ready = 1'b1;
      tick(); tick();
      check("mid_bufs_empty", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b0;
      dispatch("mid_d0", 2'b01); dispatch("mid_d1", 2'b10);
      dispatch("mid_d2", 2'b01); dispatch("mid_d3", 2'b10);
      #1;
      check("mid_credit_full", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/parser_lane_sched.md
Name: parser_lane_sched

Overview:
- Order-preserving scheduler that shares C_NUM_LANES parallel parser_do_parsing lanes between one segment stream and one downstream PHV consumer.
- Dispatches each incoming segment group round-robin to a lane, holding each lane's finished PHV in a small per-lane result buffer.
- Emits results strictly in dispatch order, with a valid/ready handshake toward the stage pipeline.
- Credit counters keep lanes that have no backpressure from overrunning their result buffers.

Parameters:
- C_NUM_LANES, 2, number of sub-parser lanes; range 2..8.
- C_LANE_IDX_W, 1, width of the lane pointers; equals clog2(C_NUM_LANES).
- C_PHV_WIDTH, 6400, width of the PHV produced by each lane.
- C_LANE_DEPTH, 2, result-buffer entries and credits per lane; power of 2, minimum 1.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  segment group plus BRAM entry present at the input.
- in_ready  out  1  the target lane has a free credit.
- lane_start  out  C_NUM_LANES  one-hot segs_valid/bram_in_valid strobe per lane.
- lane_done  in  C_NUM_LANES  per-lane parser_valid.
- lane_phv  in  C_NUM_LANES*C_PHV_WIDTH  concatenated lane PHVs; lane i occupies bits [i*C_PHV_WIDTH +: C_PHV_WIDTH].
- out_phv  out  C_PHV_WIDTH  ordered PHV.
- out_valid  out  1  out_phv is valid.
- out_ready  in  1  downstream stage accepts the PHV.
- err_overflow  out  1  sticky: a lane_done arrived while that lane's buffer was full.

Behaviour:
- Reset values: in_ready=0 while reset is high, lane_start=0, out_phv=0, out_valid=0, err_overflow=0. Both pointers reset to 0. Every credit resets to C_LANE_DEPTH. All buffers are emptied.
- Dispatch:
  - in_ready = (credit[disp_q] != 0) & ~reset.
  - A dispatch fires when in_valid & in_ready in the same cycle.
  - lane_start = fire ? onehot(disp_q) : 0. This is combinational, so there is zero added latency to the lane.
  - On the clock edge: credit[disp_q] decrements, and disp_q advances (C_NUM_LANES-1 wraps to 0).
- Stall rule: when the current lane has no credit, input stalls. The scheduler never skips to another lane; skipping would break ordering.
- Capture:
  - lane_done[i] writes lane_phv slice i into buffer i at the same edge.
  - Several lanes may complete in one cycle; all are captured.
  - If buffer i is full, the data is dropped and err_overflow sets. Only reset clears err_overflow.
- Output stage (registered):
  - Load condition: (~out_valid | out_ready) & buffer[out_q] non-empty.
  - On load: out_phv <= head of buffer[out_q], out_valid <= 1, pop the buffer, credit[out_q] increments, out_q advances with wrap.
  - If out_valid & out_ready and nothing is loadable, out_valid <= 0 and out_phv holds its value.
  - While out_valid & ~out_ready, out_phv and out_valid are held stable.
- Latency: a lane_done sampled at edge k gives out_valid=1 after edge k+1 when the output register is free.
- Throughput: one PHV per cycle when out_ready is held high.
- Simultaneous dispatch and pop on the same lane in one cycle leave that credit unchanged.
- Credits never exceed C_LANE_DEPTH; overshoot is an assertion failure.
- Reset mid-operation: everything returns to reset values in one edge. Lanes share the same reset. A lane_done in the reset cycle is discarded.

Optional Feature:
- Macro: PARSER_LANE_SCHED_STATS_EN.
- When defined, three 32-bit saturating output counters are added and zeroed by reset:
  - stat_dispatched counts fired dispatches.
  - stat_emitted counts out_valid & out_ready handshakes.
  - stat_credit_stall counts cycles with in_valid & ~in_ready.
- When undefined, these ports and the counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package parser_sched_pkg holds:
  - the PKT_HDR_LEN-derived C_PHV_WIDTH default;
  - a lane-index typedef;
  - a credit-count typedef of width clog2(C_LANE_DEPTH)+1;
  - a function returning the wrapped pointer increment.
- One sub-module, parser_lane_buf: C_LANE_DEPTH-entry register FIFO with push, pop, full, empty and head. Instantiate once per lane with generate.

Test Plan:
- Ordering: 2 lanes, depth 2, 4 back-to-back dispatches with out_ready=1. Lane 1 finishes each packet 3 cycles before lane 0 does. Expect out_phv order A,B,C,D, and no out_valid while lane 0's packet is pending.
- Credit stall: out_ready=0 with 4 dispatched. Expect in_ready=0 and stat_credit_stall incrementing on the 5th attempt. Raise out_ready; expect one PHV per cycle, and in_ready rises the cycle after the first pop.
- Hold: out_ready toggles 0,1,0,1. Expect out_phv stable whenever out_valid & ~out_ready, with no duplicates and no losses.
- Overflow: depth 1. Force lane_done on lane 0 twice with no pop. Expect err_overflow=1, with the first PHV emitted intact once out_ready=1.
- Simultaneous events: lane 0 credit=1, and dispatch to lane 0 coincides with a lane 0 pop. Expect credit stays 1 and in_ready stays 1.
- Mid-flight reset: reset asserted with 3 PHVs buffered. Next cycle expect out_valid=0, in_ready=1, and all credits = C_LANE_DEPTH.
